// File: rtl/inst_fetch_bridge_pkg.sv
// inst_fetch_bridge_pkg: shared widths, constants and state encoding for the fetch bridge
package inst_fetch_bridge_pkg;
  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_data_t;
  localparam inst_data_t ZERO_WORD = 32'h0000_0000;
  localparam inst_addr_t WORD_MASK = 32'hffff_fffc;
  localparam logic [0:0] FETCH_IDLE = 1'b0;
  localparam logic [0:0] FETCH_REQ = 1'b1;
endpackage

// File: rtl/inst_fetch_bridge_if.sv
// inst_fetch_bridge_if: req/ack read bus between the fetch bridge and instruction memory
interface inst_fetch_bridge_if;
  import inst_fetch_bridge_pkg::*;
  logic mem_req;
  inst_addr_t mem_addr;
  logic mem_ack;
  inst_data_t mem_rdata;
  modport master(output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave(input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: single-word line buffer turning the core ROM port into a req/ack fetch
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rom_ce_i,
  input  inst_addr_t rom_addr_i,
  output inst_data_t rom_data_o,
  output logic       stall_req_o,
  output logic       err_o,
  inst_fetch_bridge_if.master mem
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [0:0] state;
  logic hold_valid;
  inst_addr_t hold_addr;
  inst_addr_t req_addr;
  inst_data_t hold_data;
  logic [CW-1:0] count;
  logic hit;
  logic in_req;
  logic timeout;
  assign in_req = state == FETCH_REQ;
  assign hit = rom_ce_i & hold_valid & ((rom_addr_i & WORD_MASK) == hold_addr);
  assign timeout = count == CW'(TIMEOUT_CYCLES - 1);
  assign rom_data_o = (hit & ~rst) ? hold_data : ZERO_WORD;
  assign stall_req_o = ~rst & rom_ce_i & (in_req | ~hit);
  assign mem.mem_req = in_req;
  assign mem.mem_addr = req_addr;
  // start a fetch on a miss, then fill the line on ack or a NOP on timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH_IDLE;
      hold_valid <= 1'b0;
      hold_addr <= '0;
      hold_data <= ZERO_WORD;
      req_addr <= '0;
      count <= '0;
      err_o <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (!in_req) begin
        if (rom_ce_i & ~hit) begin
          state <= FETCH_REQ;
          req_addr <= rom_addr_i & WORD_MASK;
          count <= '0;
        end
      end else if (mem.mem_ack) begin
        hold_data <= mem.mem_rdata;
        hold_addr <= req_addr;
        hold_valid <= 1'b1;
        state <= FETCH_IDLE;
      end else if (timeout) begin
        hold_data <= ZERO_WORD;
        hold_addr <= req_addr;
        hold_valid <= 1'b1;
        err_o <= 1'b1;
        state <= FETCH_IDLE;
      end else begin
        count <= count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_bridge.sv
// tb_inst_fetch_bridge: directed scoreboard bench for the instruction fetch bridge
module tb_inst_fetch_bridge;
  import inst_fetch_bridge_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic rom_ce;
  inst_addr_t rom_addr;
  inst_data_t rom_data;
  logic stall;
  logic err;
  int compared = 0;
  int mismatched = 0;
  int stalls;
  inst_data_t exp_q[$];
  inst_data_t exp_d;
  inst_fetch_bridge_if bus();
  inst_fetch_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .rst(rst),
    .rom_ce_i(rom_ce),
    .rom_addr_i(rom_addr),
    .rom_data_o(rom_data),
    .stall_req_o(stall),
    .err_o(err),
    .mem(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pop_chk(input string tag);
    exp_d = exp_q.size() > 0 ? exp_q.pop_front() : 32'hdead_beef;
    chk({tag, "_data"}, rom_data, exp_d);
    chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    rom_ce = 1'b1;
    rom_addr = 32'h0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;
    #2;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_data", rom_data, 32'h0);
    chk("rst_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_err", {31'b0, err}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("t1_miss_stall", {31'b0, stall}, 32'd1);
    chk("t1_miss_noreq", {31'b0, bus.mem_req}, 32'd0);
    step();
    chk("t1_req", {31'b0, bus.mem_req}, 32'd1);
    chk("t1_addr", bus.mem_addr, 32'h0);
    chk("t1_req_stall", {31'b0, stall}, 32'd1);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h3401_1100;
    exp_q.push_back(32'h3401_1100);
    step();
    bus.mem_ack = 1'b0;
    #1;
    pop_chk("t1_fill");
    rom_addr = 32'h2;
    #1;
    chk("t2_hit_data", rom_data, 32'h3401_1100);
    chk("t2_hit_stall", {31'b0, stall}, 32'd0);
    step();
    chk("t2_noreq", {31'b0, bus.mem_req}, 32'd0);
    rom_addr = 32'h4;
    stalls = 0;
    #1;
    if (stall) stalls++;
    chk("t3_miss_noreq", {31'b0, bus.mem_req}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (stall) stalls++;
      chk("t3_req", {31'b0, bus.mem_req}, 32'd1);
      chk("t3_addr", bus.mem_addr, 32'h4);
      if (k == 5) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'haabb_ccdd;
        exp_q.push_back(32'haabb_ccdd);
      end
    end
    step();
    bus.mem_ack = 1'b0;
    #1;
    if (stall) stalls++;
    pop_chk("t3_fill");
    chk("t3_stall_cycles", stalls, 32'd6);
    rom_addr = 32'h10;
    #1;
    chk("t4_miss_stall", {31'b0, stall}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t4_req", {31'b0, bus.mem_req}, 32'd1);
      chk("t4_noerr", {31'b0, err}, 32'd0);
    end
    step();
    chk("t4_req_drop", {31'b0, bus.mem_req}, 32'd0);
    chk("t4_err", {31'b0, err}, 32'd1);
    exp_q.push_back(32'h0);
    pop_chk("t4_nop");
    step();
    chk("t4_err_once", {31'b0, err}, 32'd0);
    chk("t4_hold_stall", {31'b0, stall}, 32'd0);
    rom_addr = 32'h14;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 8) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h1122_3344;
        exp_q.push_back(32'h1122_3344);
      end
    end
    step();
    bus.mem_ack = 1'b0;
    #1;
    chk("tb_ack_wins_err", {31'b0, err}, 32'd0);
    pop_chk("tb_ack_wins");
    rom_addr = 32'h18;
    step();
    chk("t5_req", {31'b0, bus.mem_req}, 32'd1);
    step();
    rst = 1'b1;
    #1;
    chk("t5_rst_req", {31'b0, bus.mem_req}, 32'd0);
    chk("t5_rst_stall", {31'b0, stall}, 32'd0);
    chk("t5_rst_data", rom_data, 32'h0);
    rst = 1'b0;
    #1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hbad0_bad0;
    #1;
    chk("t5_late_ack_stall", {31'b0, stall}, 32'd1);
    chk("t5_late_ack_noreq", {31'b0, bus.mem_req}, 32'd0);
    step();
    bus.mem_ack = 1'b0;
    #1;
    chk("t5_remiss_req", {31'b0, bus.mem_req}, 32'd1);
    chk("t5_remiss_addr", bus.mem_addr, 32'h18);
    chk("t5_remiss_stall", {31'b0, stall}, 32'd1);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h0f0f_0f0f;
    exp_q.push_back(32'h0f0f_0f0f);
    step();
    bus.mem_ack = 1'b0;
    #1;
    pop_chk("t5_fill");
    rom_addr = 32'h8;
    #1;
    chk("t6_miss_stall", {31'b0, stall}, 32'd1);
    step();
    chk("t6_req8", bus.mem_addr, 32'h8);
    rom_addr = 32'hc;
    #1;
    chk("t6_switch_stall", {31'b0, stall}, 32'd1);
    chk("t6_addr_stable", bus.mem_addr, 32'h8);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h0808_0808;
    step();
    bus.mem_ack = 1'b0;
    #1;
    chk("t6_idle_stall", {31'b0, stall}, 32'd1);
    chk("t6_idle_noreq", {31'b0, bus.mem_req}, 32'd0);
    step();
    chk("t6_reqc", {31'b0, bus.mem_req}, 32'd1);
    chk("t6_addrc", bus.mem_addr, 32'hc);
    chk("t6_reqc_stall", {31'b0, stall}, 32'd1);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h0c0c_0c0c;
    exp_q.push_back(32'h0c0c_0c0c);
    step();
    bus.mem_ack = 1'b0;
    #1;
    pop_chk("t6_fillc");
    rom_addr = 32'h8;
    #1;
    chk("t6_replaced_stall", {31'b0, stall}, 32'd1);
    rom_ce = 1'b0;
    #1;
    chk("ce0_stall", {31'b0, stall}, 32'd0);
    chk("ce0_data", rom_data, 32'h0);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
